// File: rtl/neuron_layer_seq.sv
// -----------------------------------------------------------------------------
// neuron_layer_seq
//
// Time-multiplexed sequencer for one fully-connected ReLU layer. One shared
// multiply-accumulate datapath evaluates NUM_NEURONS neurons in turn. It
// latches a NUM_INPUTS-element activation vector, then for each neuron it
// streams the weights and the bias from an external synchronous weight memory.
// Each result goes through ReLU and is emitted on a valid/ready stream.
//
// Weight memory layout: the weight for neuron j, input k is at address
// j*(NUM_INPUTS+1)+k. The bias for neuron j is at j*(NUM_INPUTS+1)+NUM_INPUTS.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   activation beat valid
//   in_ready   block accepts an activation beat (IDLE/LOAD)
//   in_data    activation, signed Q8.8
//   w_en       weight-memory read enable
//   w_addr     weight-memory read address
//   w_data     weight-memory read data, signed Q8.8, one cycle after w_en
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   ReLU result, Q8.8, never negative
//   out_idx    neuron index of out_data
//   out_last   high with the result of neuron NUM_NEURONS-1
//   busy       high in any state other than IDLE
//
// Optional build macro:
//   NEURON_LAYER_SEQ_ROUND_EN  finalize rounds half up ((acc+128)>>>8)
//                              instead of truncating toward -inf. Timing is
//                              the same in both builds.
// -----------------------------------------------------------------------------
module neuron_layer_seq #(
    parameter int NUM_INPUTS  = 5,
    parameter int NUM_NEURONS = 8,
    parameter int ACC_W       = 40,
    parameter int ADDR_W      = 6,
    parameter int IDX_W       = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [15:0]       w_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_MAC  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    // One counter width serves both the input-beat count and the MAC cycle.
    localparam int                 C_W    = $clog2(NUM_INPUTS + 2);
    localparam logic [C_W-1:0]     C_LAST = C_W'(NUM_INPUTS + 1);
    localparam logic [C_W-1:0]     K_LAST = C_W'(NUM_INPUTS - 1);
    localparam logic [IDX_W-1:0]   J_LAST = IDX_W'(NUM_NEURONS - 1);
    localparam logic [ADDR_W-1:0]  STRIDE = ADDR_W'(NUM_INPUTS + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);

    logic [1:0]              r_state;
    logic [C_W-1:0]          r_k;
    logic [C_W-1:0]          r_c;
    logic [IDX_W-1:0]        r_j;
    logic signed [ACC_W-1:0] r_acc;
    logic [15:0]             r_x [NUM_INPUTS];

    logic                    r_in_ready;
    logic                    r_w_en;
    logic [ADDR_W-1:0]       r_w_addr;
    logic                    r_out_valid;
    logic [15:0]             r_out_data;
    logic [IDX_W-1:0]        r_out_idx;
    logic                    r_out_last;
    logic                    r_busy;

    logic [1:0]              w_state_nxt;
    logic [C_W-1:0]          w_k_nxt;
    logic [C_W-1:0]          w_c_nxt;
    logic [IDX_W-1:0]        w_j_nxt;
    logic                    w_accept;
    logic                    w_out_hs;
    logic                    w_fin;
    logic                    w_en_nxt;
    logic [ADDR_W-1:0]       w_addr_nxt;

    logic signed [15:0]      w_x_sel;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_acc_add;
    logic signed [ACC_W-1:0] w_acc_sum;

    // Shift Q16.16 back to Q8.8, saturate to 16-bit signed, then apply ReLU.
    // A negative value saturates to -32768 at worst, which ReLU maps to 0.
    function automatic logic [15:0] finalize(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
`ifdef NEURON_LAYER_SEQ_ROUND_EN
        r = $signed(acc + ACC_W'(128)) >>> 8;
`else
        r = acc >>> 8;
`endif
        if (r[ACC_W-1]) begin
            finalize = 16'h0000;
        end else if (r > SAT_MAX) begin
            finalize = 16'h7FFF;
        end else begin
            finalize = r[15:0];
        end
    endfunction

    // Next-state and counter logic of the sequencer.
    always_comb begin
        w_accept    = in_valid && r_in_ready;
        w_out_hs    = r_out_valid && out_ready;
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_c_nxt     = r_c;
        w_j_nxt     = r_j;
        w_fin       = 1'b0;
        case (r_state)
            S_IDLE, S_LOAD: begin
                if (w_accept) begin
                    if (r_k == K_LAST) begin
                        w_state_nxt = S_MAC;
                        w_k_nxt     = {C_W{1'b0}};
                        w_c_nxt     = {C_W{1'b0}};
                        w_j_nxt     = {IDX_W{1'b0}};
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_k_nxt     = r_k + C_W'(1);
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_MAC: begin
                if (r_c == C_LAST) begin
                    w_state_nxt = S_OUT;
                    w_fin       = 1'b1;
                end else begin
                    w_c_nxt = r_c + C_W'(1);
                end
            end
            S_OUT: begin
                if (w_out_hs) begin
                    if (r_j == J_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_j_nxt     = {IDX_W{1'b0}};
                    end else begin
                        w_state_nxt = S_MAC;
                        w_j_nxt     = r_j + IDX_W'(1);
                        w_c_nxt     = {C_W{1'b0}};
                    end
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = {C_W{1'b0}};
                w_c_nxt     = {C_W{1'b0}};
                w_j_nxt     = {IDX_W{1'b0}};
            end
        endcase
    end

    // Memory reads are issued for MAC cycles 0..NUM_INPUTS; the final cycle
    // only consumes the bias returned by the previous read.
    always_comb begin
        w_en_nxt   = (w_state_nxt == S_MAC) && (w_c_nxt != C_LAST);
        w_addr_nxt = ADDR_W'(w_j_nxt) * STRIDE + ADDR_W'(w_c_nxt);
    end

    // Pick x[c-1] for the weight arriving in MAC cycle c.
    always_comb begin
        w_x_sel = 16'sd0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_c == C_W'(i + 1)) begin
                w_x_sel = r_x[i];
            end else begin
                w_x_sel = w_x_sel;
            end
        end
    end

    // Accumulator increment: products in cycles 1..NUM_INPUTS, bias (<<<8 to
    // align with the Q16.16 products) in the last cycle.
    always_comb begin
        w_prod = w_x_sel * $signed(w_data);
        if (r_state == S_MAC && r_c == C_LAST) begin
            w_acc_add = {{(ACC_W-24){w_data[15]}}, w_data, 8'h00};
        end else if (r_state == S_MAC && r_c != {C_W{1'b0}}) begin
            w_acc_add = {{(ACC_W-32){w_prod[31]}}, w_prod};
        end else begin
            w_acc_add = {ACC_W{1'b0}};
        end
        w_acc_sum = r_acc + w_acc_add;
    end

    // Sequencer state and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= {C_W{1'b0}};
            r_c     <= {C_W{1'b0}};
            r_j     <= {IDX_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_c     <= w_c_nxt;
            r_j     <= w_j_nxt;
        end
    end

    // Activation vector capture and accumulator; the accumulator clears on
    // every entry into MAC and freezes outside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= {ACC_W{1'b0}};
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_x[i] <= 16'h0000;
            end
        end else begin
            if (w_accept) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (r_k == C_W'(i)) begin
                        r_x[i] <= in_data;
                    end
                end
            end
            if (r_state != S_MAC && w_state_nxt == S_MAC) begin
                r_acc <= {ACC_W{1'b0}};
            end else if (r_state == S_MAC) begin
                r_acc <= w_acc_sum;
            end
        end
    end

    // Registered interface outputs, derived from the next state so that they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_w_en      <= 1'b0;
            r_w_addr    <= {ADDR_W{1'b0}};
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_idx   <= {IDX_W{1'b0}};
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_w_en      <= w_en_nxt;
            r_out_valid <= (w_state_nxt == S_OUT);
            if (w_en_nxt) begin
                r_w_addr <= w_addr_nxt;
            end
            if (w_fin) begin
                r_out_data <= finalize(w_acc_sum);
                r_out_idx  <= r_j;
                r_out_last <= (r_j == J_LAST);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign w_en      = r_w_en;
    assign w_addr    = r_w_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_neuron_layer_seq.sv
// -----------------------------------------------------------------------------
// Testbench for neuron_layer_seq (default parameters: 5 inputs, 8 neurons).
// Table rows give the activation vector plus hand-computed weights/results for
// neurons 0 and 1; neurons 2..7 get random weights and a reference model.
// Expected results go into a scoreboard queue when a vector is loaded and are
// popped by a monitor on every output handshake. The monitor also checks
// latency, stall behaviour and in_ready around the layer boundary.
// -----------------------------------------------------------------------------
module tb_neuron_layer_seq;

    localparam int NI = 5;
    localparam int NN = 8;
    localparam int AW = 6;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data = 16'h0000;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_data = 16'h0000;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    neuron_layer_seq dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous weight memory: data one cycle after the read enable.
    logic [15:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (w_en) w_data <= mem[w_addr];
    end

    typedef struct packed {
        logic [4:0][15:0] x;
        logic [4:0][15:0] w0;
        logic [15:0]      b0;
        logic [15:0]      e0;
        logic [4:0][15:0] w1;
        logic [15:0]      b1;
        logic [15:0]      e1;
        logic [1:0]       rdy;
        logic [1:0]       gap;
    } row_t;

    typedef struct packed {
        logic [15:0]   data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    row_t        rows [4];
    exp_t        sb [$];
    logic [15:0] cur_x [NI];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          rcnt = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact Q16.16 sum in 64 bits, shift, saturate, ReLU.
    function automatic logic [15:0] model(input int j);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < NI; k++) begin
            acc += longint'($signed(cur_x[k])) * longint'($signed(mem[j*(NI+1)+k]));
        end
        acc += longint'($signed(mem[j*(NI+1)+NI])) * 256;
`ifdef NEURON_LAYER_SEQ_ROUND_EN
        r = (acc + 128) >>> 8;
`else
        r = acc >>> 8;
`endif
        if (r < 0) return 16'h0000;
        if (r > 32767) return 16'h7FFF;
        return r[15:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready pattern generator, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    bit            prev_w_en = 1'b0;
    bit            prev_ov = 1'b0;
    bit            last_done = 1'b0;
    int            t_wen = 0;
    logic [15:0]   hold_data;
    logic [IW-1:0] hold_idx;
    logic          hold_last;
    exp_t          e;

    always @(negedge clk) begin
        if (reset) begin
            prev_w_en = 1'b0;
            prev_ov   = 1'b0;
            last_done = 1'b0;
        end else begin
            if (w_en && !prev_w_en) t_wen = cyc;
            if (out_valid && !prev_ov) begin
                check((cyc - t_wen) == NI + 2, "latency", cyc - t_wen, NI + 2);
                hold_data = out_data;
                hold_idx  = out_idx;
                hold_last = out_last;
            end else if (out_valid && prev_ov) begin
                check(w_en == 1'b0, "stall_w_en", w_en, 0);
                check(out_data == hold_data && out_idx == hold_idx && out_last == hold_last,
                      "stall_stable", {out_data, out_idx, out_last}, {hold_data, hold_idx, hold_last});
            end
            if (out_valid) check(in_ready == 1'b0, "in_ready_in_out", in_ready, 0);
            if (last_done) begin
                check(in_ready == 1'b1 && busy == 1'b0, "idle_after_last", {in_ready, busy}, 2'b10);
                last_done = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_output", out_idx, 0);
                end else begin
                    e = sb.pop_front();
                    check(out_data == e.data, "out_data", out_data, e.data);
                    check(out_idx == e.idx, "out_idx", out_idx, e.idx);
                    check(out_last == e.last, "out_last", out_last, e.last);
                    if (out_last) last_done = 1'b1;
                end
            end
            prev_w_en = w_en;
            prev_ov   = out_valid;
        end
    end

    task automatic check_reset_vals();
        check(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
        check(w_en == 1'b0, "rst_w_en", w_en, 0);
        check(w_addr == '0, "rst_w_addr", w_addr, 0);
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check(out_data == 16'h0000, "rst_out_data", out_data, 0);
        check(out_idx == '0, "rst_out_idx", out_idx, 0);
        check(out_last == 1'b0, "rst_out_last", out_last, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
    endtask

    // Fill memory for one row, set the vector and queue the 8 expected results.
    task automatic load_row(input int r);
        exp_t ex;
        for (int k = 0; k < NI; k++) cur_x[k] = rows[r].x[k];
        for (int j = 0; j < NN; j++) begin
            for (int k = 0; k <= NI; k++) begin
                if (j == 0) mem[j*(NI+1)+k] = (k == NI) ? rows[r].b0 : rows[r].w0[k];
                else if (j == 1) mem[j*(NI+1)+k] = (k == NI) ? rows[r].b1 : rows[r].w1[k];
                else mem[j*(NI+1)+k] = 16'($urandom_range(0, 65535));
            end
        end
        for (int j = 0; j < NN; j++) begin
            ex.data = (j == 0) ? rows[r].e0 : (j == 1) ? rows[r].e1 : model(j);
            ex.idx  = IW'(j);
            ex.last = (j == NN - 1);
            sb.push_back(ex);
        end
    endtask

    task automatic send_vec(input int gap);
        int tmo;
        for (int k = 0; k < NI; k++) begin
            in_valid = 1'b1;
            in_data  = cur_x[k];
            tmo = 0;
            while (!in_ready && tmo < 500) begin
                @(posedge clk);
                #1;
                tmo++;
            end
            if (tmo >= 500) check(1'b0, "in_ready_timeout", k, 0);
            @(posedge clk);
            #1;
            if (gap > 0 && k < NI - 1) begin
                in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int tmo;
        tmo = 0;
        while ((sb.size() != 0 || busy) && tmo < 3000) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        if (tmo >= 3000) begin
            check(1'b0, "done_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int tmo_m;

    initial begin
        // x/w vectors are written element 4 first, element 0 last.
        rows[0] = '{x: {5{16'h0100}}, w0: {5{16'h0100}}, b0: 16'h0080, e0: 16'h0580,
                    w1: {5{16'hFF00}}, b1: 16'h0000, e1: 16'h0000, rdy: 2'd0, gap: 2'd0};
        rows[1] = '{x: {5{16'h7F00}}, w0: {5{16'h7F00}}, b0: 16'h7FFF, e0: 16'h7FFF,
                    w1: {5{16'h8100}}, b1: 16'h0000, e1: 16'h0000, rdy: 2'd2, gap: 2'd2};
        rows[2] = '{x: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001},
                    w0: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0080}, b0: 16'h0000, e0: 16'h0000,
                    w1: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0180}, b1: 16'h0000, e1: 16'h0001,
                    rdy: 2'd0, gap: 2'd1};
`ifdef NEURON_LAYER_SEQ_ROUND_EN
        rows[2].e0 = 16'h0001;
        rows[2].e1 = 16'h0002;
`endif
        rows[3] = '{x: {16'h0100, 16'h0000, 16'h0040, 16'hFF80, 16'h0200},
                    w0: {16'hFFFF, 16'h7FFF, 16'h0400, 16'h0200, 16'h0100}, b0: 16'hFF00, e0: 16'h00FF,
                    w1: {5{16'h0080}}, b1: 16'h0010, e1: 16'h0170, rdy: 2'd1, gap: 2'd0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        #1 reset = 1'b0;

        for (int r = 0; r < 4; r++) begin
            rdy_mode = int'(rows[r].rdy);
            load_row(r);
            send_vec(int'(rows[r].gap));
            wait_done();
        end

        // Abort in the middle of neuron 3, MAC cycle 2 (address 3*6+2).
        rdy_mode = 0;
        load_row(0);
        send_vec(0);
        tmo_m = 0;
        do begin
            @(negedge clk);
            tmo_m++;
        end while (!(w_en && w_addr == AW'(3*(NI+1)+2)) && tmo_m < 500);
        if (tmo_m >= 500) check(1'b0, "mid_mac_timeout", w_addr, 3*(NI+1)+2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        sb.delete();
        #1 reset = 1'b0;
        load_row(3);
        rdy_mode = 2;
        send_vec(0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
